// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// The size encoding matches the core's load/store size field.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input size_e size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_lanes(input logic [1:0] lane, input size_e size);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and the responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word array with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one request at a time, fixed wait states, byte/half/word
// access with extension and error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e          state, state_nx;
    logic [3:0]      cnt;
    logic            lat_we, lat_uns, lat_err;
    size_e           lat_size;
    logic [1:0]      lat_lane;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;

    size_e           req_size;
    logic            accept, req_err, access;
    logic            a_we;
    size_e           a_size;
    logic [1:0]      a_lane;
    logic [31:0]     a_wdata;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;

    assign req_size = size_e'(bus.req_size);
    assign accept   = (state == ST_IDLE) && bus.req_valid;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_HALF:    req_err = bus.req_addr[0];
            SZ_WORD:    req_err = |bus.req_addr[1:0];
            SZ_ILLEGAL: req_err = 1'b1;
            default:    req_err = 1'b0;
        endcase
        if ((bus.req_addr >> (AW + 2)) != 32'd0) req_err = 1'b1;
    end

    always_comb begin
        state_nx = state;
        access   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_nx = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        access   = 1'b1;
                        state_nx = ST_RESP;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    access   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: if (bus.rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // In IDLE the access (zero-wait case) comes straight from the bus; later it uses the latched copy.
    always_comb begin
        if (state == ST_IDLE) begin
            a_we     = bus.req_we;
            a_size   = req_size;
            a_lane   = bus.req_addr[1:0];
            a_wdata  = bus.req_wdata;
            ram_addr = bus.req_addr[AW+1:2];
        end else begin
            a_we     = lat_we;
            a_size   = lat_size;
            a_lane   = lat_lane;
            a_wdata  = lat_wdata;
            ram_addr = lat_idx;
        end
        ram_we = access && a_we;
        ram_be = store_lanes(a_lane, a_size);
        case (a_size)
            SZ_BYTE: ram_wdata = {4{a_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{a_wdata[15:0]}};
            default: ram_wdata = a_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_err   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_lane  <= 2'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            lat_we    <= bus.req_we;
            lat_uns   <= bus.req_unsigned;
            lat_err   <= req_err;
            lat_size  <= req_size;
            lat_lane  <= bus.req_addr[1:0];
            lat_idx   <= bus.req_addr[AW+1:2];
            lat_wdata <= bus.req_wdata;
        end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM keeps re-reading the latched word in RESP with no writes, so the load data holds.
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_err   = (state == ST_RESP) && lat_err;
    assign bus.rsp_rdata = (state == ST_RESP && !lat_err && !lat_we)
                         ? load_extend(ram_rdata, lat_lane, lat_size, lat_uns) : 32'd0;
endmodule
